// File: rtl/oneshot_multi.sv
// oneshot_multi: NUM_CH independent one-shot pulse generators.
// Each channel turns a qualifying edge on its trigger into a pulse PULSE_LEN cycles wide.
// Edge modes are none, rise, fall or both. Each channel has its own enable,
// optional retrigger and a sticky missed-event flag.
// Optional macro ONESHOT_MULTI_SYNC_EN places a 2-flop synchroniser in front of
// edge detection on every trigger input. Trigger-to-pulse latency then becomes 3 cycles.
module oneshot_multi #(
  parameter int NUM_CH    = 4,
  parameter int PULSE_LEN = 1,
  parameter int RETRIG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     en,
  input  logic [2*NUM_CH-1:0]   edge_sel,
  input  logic [NUM_CH-1:0]     trig,
  input  logic                  clr_miss,
  output logic [NUM_CH-1:0]     pulse,
  output logic [NUM_CH-1:0]     miss,
  output logic                  any_pulse
);

  localparam int            CW      = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] LOAD    = CW'(PULSE_LEN - 1);
  localparam logic          S_IDLE  = 1'b0;
  localparam logic          S_PULSE = 1'b1;

  logic [NUM_CH-1:0] w_trig;
  logic [NUM_CH-1:0] r_prev;
  logic [NUM_CH-1:0] w_qual;
  logic [NUM_CH-1:0] r_state;
  logic [NUM_CH-1:0] w_state_nxt;
  logic [CW-1:0]     r_cnt     [NUM_CH];
  logic [CW-1:0]     w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_miss_set;
  logic [NUM_CH-1:0] r_miss;

`ifdef ONESHOT_MULTI_SYNC_EN
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;

  // Two-flop synchroniser on every trigger input before edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= trig;
      r_sync2 <= r_sync1;
    end
  end

  assign w_trig = r_sync2;
`else
  assign w_trig = trig;
`endif

  // Trigger history. It updates every cycle regardless of enable or state.
  // A reset value of 0 makes trig high on the first clock after reset count as a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= '0;
    else     r_prev <= w_trig;
  end

  // Qualify each channel's edge against its mode bits: bit 0 = rise, bit 1 = fall.
  always_comb begin
    w_qual = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_qual[i] = (edge_sel[2*i]   & w_trig[i] & ~r_prev[i]) |
                  (edge_sel[2*i+1] & ~w_trig[i] & r_prev[i]);
    end
  end

  // Per-channel FSM state and counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= {NUM_CH{S_IDLE}};
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // Next-state logic. Priority inside PULSE is: enable drop, then retrigger or miss, then countdown.
  always_comb begin
    w_state_nxt = r_state;
    w_miss_set  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (r_state[i] == S_IDLE) begin
        if (en[i] && w_qual[i]) begin
          w_state_nxt[i] = S_PULSE;
          w_cnt_nxt[i]   = LOAD;
        end
      end else begin
        if (!en[i]) begin
          w_state_nxt[i] = S_IDLE;
          w_cnt_nxt[i]   = '0;
        end else if (w_qual[i] && (RETRIG != 0)) begin
          w_cnt_nxt[i]   = LOAD;
        end else begin
          // A dropped edge is still recorded on the terminal-count cycle, and no new pulse follows.
          if (w_qual[i]) w_miss_set[i] = 1'b1;
          if (r_cnt[i] == '0) w_state_nxt[i] = S_IDLE;
          else                w_cnt_nxt[i]   = r_cnt[i] - CW'(1);
        end
      end
    end
  end

  // Sticky miss flags. A set in the same cycle wins over clr_miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_miss <= '0;
    else     r_miss <= w_miss_set | (r_miss & ~{NUM_CH{clr_miss}});
  end

  // Outputs decode straight from registers, so an asynchronous reset drops the pulse at once.
  always_comb begin
    pulse     = r_state;
    miss      = r_miss;
    any_pulse = |r_state;
  end

endmodule

// File: tb/tb_oneshot_multi.sv
// Testbench for oneshot_multi. It drives two instances from shared inputs:
// one with PULSE_LEN=4 and RETRIG=0, one with PULSE_LEN=3 and RETRIG=1.
// A reference model tracks, for each channel, how many high cycles of the pulse remain.
module tb_oneshot_multi;

  localparam int N  = 4;
  localparam int L0 = 4;
  localparam int L1 = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   en  = '0;
  logic [2*N-1:0] sel = '0;
  logic [N-1:0]   trig = '0;
  logic           clr = 1'b0;
  logic [N-1:0]   p0, m0, p1, m1;
  logic           a0, a1;

  int total = 0;
  int bad   = 0;

  int           rem0 [N];
  int           rem1 [N];
  logic [N-1:0] em0, em1, prev;

  always #5 clk = ~clk;

  oneshot_multi #(.NUM_CH(N), .PULSE_LEN(L0), .RETRIG(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .edge_sel(sel), .trig(trig), .clr_miss(clr),
    .pulse(p0), .miss(m0), .any_pulse(a0));

  oneshot_multi #(.NUM_CH(N), .PULSE_LEN(L1), .RETRIG(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .edge_sel(sel), .trig(trig), .clr_miss(clr),
    .pulse(p1), .miss(m1), .any_pulse(a1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      rem0[i] = 0;
      rem1[i] = 0;
    end
    em0  = '0;
    em1  = '0;
    prev = '0;
  endtask

  // One clock of behaviour for both configurations, using the inputs as the DUT will sample them.
  task automatic model_cycle();
    logic q;
    for (int i = 0; i < N; i++) begin
      q = (sel[2*i] && trig[i] && !prev[i]) || (sel[2*i+1] && !trig[i] && prev[i]);
      if (clr) begin
        em0[i] = 1'b0;
        em1[i] = 1'b0;
      end
      // PULSE_LEN=4, no retrigger
      if (!en[i])          rem0[i] = 0;
      else if (rem0[i] == 0) rem0[i] = q ? L0 : 0;
      else begin
        if (q) em0[i] = 1'b1;
        rem0[i] = rem0[i] - 1;
      end
      // PULSE_LEN=3, retrigger
      if (!en[i])          rem1[i] = 0;
      else if (rem1[i] == 0) rem1[i] = q ? L1 : 0;
      else if (q)          rem1[i] = L1;
      else                 rem1[i] = rem1[i] - 1;
    end
    prev = trig;
  endtask

  task automatic compare(input string tag);
    logic [N-1:0] e0, e1;
    for (int i = 0; i < N; i++) begin
      e0[i] = (rem0[i] > 0);
      e1[i] = (rem1[i] > 0);
    end
    chk({tag, ".pulse0"}, 32'(p0), 32'(e0));
    chk({tag, ".miss0"},  32'(m0), 32'(em0));
    chk({tag, ".any0"},   32'(a0), 32'(|e0));
    chk({tag, ".pulse1"}, 32'(p1), 32'(e1));
    chk({tag, ".miss1"},  32'(m1), 32'(em1));
    chk({tag, ".any1"},   32'(a1), 32'(|e1));
  endtask

  // Inputs are set just after a rising edge. This task clocks once and checks 1 time unit later.
  task automatic step(input string tag);
    model_cycle();
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  // Assert the asynchronous reset between clock edges. Outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".rst_pulse0"}, 32'(p0), 32'd0);
    chk({tag, ".rst_pulse1"}, 32'(p1), 32'd0);
    chk({tag, ".rst_any0"},   32'(a0), 32'd0);
    chk({tag, ".rst_miss0"},  32'(m0), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset("init");
    compare("init");

    // Single rise on ch0 with trig held high: one pulse, none on the hold or the fall.
    en  = '1;
    sel = 8'h55;
    trig[0] = 1'b1;
    step("t1");
    chk("t1.lat", 32'(p0[0]), 32'd1);
    chk("t1.any", 32'(a0), 32'd1);
    repeat (4) step("t1h");
    trig[0] = 1'b0;
    repeat (5) step("t1f");
    chk("t1.idle", 32'(p0), 32'd0);

    // Falling-edge mode on ch1.
    sel = 8'h59;
    trig[1] = 1'b1;
    repeat (2) step("t2r");
    chk("t2.norise", 32'(p0[1]), 32'd0);
    trig[1] = 1'b0;
    step("t2f");
    chk("t2.fall", 32'(p0[1]), 32'd1);
    repeat (5) step("t2t");

    // Both-edge mode on ch2: a second edge mid-pulse is a miss without retrigger and extends the pulse with retrigger.
    sel = 8'hFF;
    trig[2] = 1'b1;
    repeat (2) step("t3r");
    trig[2] = 1'b0;
    repeat (5) step("t3f");
    chk("t3.miss0", 32'(m0[2]), 32'd1);
    chk("t3.miss1", 32'(m1[2]), 32'd0);
    clr = 1'b1;
    step("t3c");
    clr = 1'b0;
    chk("t3.clr", 32'(m0[2]), 32'd0);

    // Reset while trig[3] is high: a rise follows on the first clock after release.
    trig[3] = 1'b1;
    repeat (2) step("t5a");
    do_reset("t5");
    step("t5b");
    chk("t5.pulse0", 32'(p0[3]), 32'd1);
    chk("t5.pulse1", 32'(p1[3]), 32'd1);
    do_reset("t5m");
    trig[3] = 1'b0;
    step("t5c");

    // Enable dropped mid-pulse, then edges while disabled.
    trig[0] = 1'b1;
    repeat (2) step("t6a");
    en[0] = 1'b0;
    step("t6b");
    chk("t6.off", 32'(p0[0]), 32'd0);
    chk("t6.nomiss", 32'(m0[0]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      trig[0] = ~trig[0];
      step("t6c");
    end
    en[0] = 1'b1;
    repeat (4) step("t6d");

    // Randomised traffic.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0)  trig[i] = ~trig[i];
        if ($urandom_range(15) == 0) en[i]   = ~en[i];
      end
      if ($urandom_range(31) == 0) sel = 8'($urandom);
      clr = ($urandom_range(11) == 0);
      if ($urandom_range(599) == 0) begin
        clr = 1'b0;
        do_reset("rnd");
      end else begin
        step("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
